// File: rtl/reg_file.sv
// reg_file: multi-port register file, one write port, NUM_RD registered read ports, write-first bypass
//   clk, rst            : clock, synchronous active-high reset (clears storage and read lanes)
//   we, waddr, wdata    : write port
//   re[NUM_RD]          : per-port read enable; a disabled lane holds its value
//   raddr[NUM_RD*ADDR_W]: read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata[NUM_RD*WIDTH] : registered read data, port i at [i*WIDTH +: WIDTH]
module reg_file #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*WIDTH-1:0]  rdata
);
    localparam int DEPTH = 2**ADDR_W;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [NUM_RD*WIDTH-1:0] rdata_q, rdata_d;
    logic wr_ok;
    // reads index the post-write image, which gives write-first bypass for free
    always_comb begin
        wr_ok = we && !(ZERO_REG != 0 && waddr == '0);
        mem_d = mem_q;
        if (wr_ok) mem_d[waddr] = wdata;
        rdata_d = rdata_q;
        for (int i = 0; i < NUM_RD; i++)
            if (re[i])
                rdata_d[i*WIDTH +: WIDTH] = (ZERO_REG != 0 && raddr[i*ADDR_W +: ADDR_W] == '0) ? '0
                                          : mem_d[raddr[i*ADDR_W +: ADDR_W]];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end
    assign rdata = rdata_q;
endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-port register file: the successor to the single 16-bit enable-register, used as the CPU general-purpose register bank. One synchronous write port and NUM_RD synchronous read ports with registered outputs. Same-cycle write-to-read bypass, optional hard-wired zero register. Sits between decode (addresses and enables) and the ALU operand muxes (read data) / writeback stage (write port).

## Interface
- WIDTH, 16: data width in bits, ≥1.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2: number of read ports, ≥1.
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- re  in  NUM_RD  per-port read enable; bit i controls port i.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*WIDTH  registered read data; port i at bits [i*WIDTH +: WIDTH].

## Operation
- Storage: DEPTH entries of WIDTH bits.
- Reset (rst=1 at a rising edge): every entry and every rdata lane cleared to 0. rst overrides we and re in the same cycle; the write and reads of that cycle are discarded.
- Write: we=1 at a rising edge → entry[waddr] <= wdata. we=0 → all entries hold.
- ZERO_REG=1 and waddr=0: write dropped, entry 0 stays 0.
- Read, port i: re[i]=1 at a rising edge → rdata lane i <= value of entry[raddr_i] as seen by that edge, after bypass. re[i]=0 → lane i holds its previous value (no change, no X).
- Bypass (write-first): re[i]=1, we=1, raddr_i==waddr in the same cycle → lane i <= wdata, not the old entry contents. Bypass is suppressed when ZERO_REG=1 and the address is 0; that lane loads 0.
- ZERO_REG=1, raddr_i=0, re[i]=1 → lane i <= 0.
- Ports are independent. Any number of ports may read the same address, including the write address, in one cycle; all receive the same value.
- No address range checks are needed. The address width spans DEPTH exactly, so every address is valid.

## Timing
- Read latency: 1 cycle. Address and enable are sampled at edge N; rdata is valid after edge N and stable until the next edge with re[i]=1 or rst=1.
- Write visibility: a write at edge N is visible to a read sampled at edge N (bypass) and at every later edge.
- Back-to-back writes to the same address: the last one wins; a read in each cycle tracks each written value.
- Reset: rdata is 0 from the first edge with rst=1. Storage reads 0 on the first read after rst is released. No outputs depend combinationally on inputs.

## Test plan
- Reset clears everything: write 0xBEEF to r3, then rst=1 for 1 cycle, then read r3 on port 0 → rdata0=0x0000 one cycle after the read edge. All lanes are 0 during reset.
- Basic write/read with latency: write 0x1234 to r5 at edge 1; at edge 2 set raddr0=5, re0=1 → rdata0=0x1234 after edge 2 and not before.
- Bypass: r2 holds 0x00AA; in one cycle set we=1, waddr=2, wdata=0x5555, re=2'b11, raddr0=raddr1=2 → both lanes read 0x5555 after that edge, and a later read also gives 0x5555.
- Hold on re=0: lane 1 reads r1=0x0F0F; then r1 is overwritten with 0xF0F0 while re1=0 → rdata1 stays 0x0F0F. The next re1=1 reads 0xF0F0.
- Zero register (ZERO_REG=1): write 0xFFFF to r0 with re0=1, raddr0=0 in the same cycle → rdata0=0. A later read of r0 also gives 0.
- Reset mid-operation: assert rst with we=1, waddr=4, wdata=0x7777, re0=1, raddr0=4 → rdata0=0 and r4 reads 0 afterwards. Repeat the suite with WIDTH=8, ADDR_W=4, NUM_RD=3 to cover parametrisation.
